// File: rtl/lsu_align_unit.sv
// rtl/lsu_align_unit.sv - RV32I load/store alignment unit
// Splits misaligned accesses into two word accesses and extends load data.
module lsu_align_unit #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign,
  output logic        bad_op
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state, state_nx;
  logic [31:0] lo_buf;
  logic [1:0]  off;
  logic [4:0]  sh;
  logic        bad, mis, ld_en;
  logic [3:0]  base_mask;
  logic [7:0]  mask8;
  logic [63:0] wshift, lshift;
  logic [31:0] raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo_buf <= '0;
    end else begin
      state <= state_nx;
      if (stall) lo_buf <= mem_rdata;
    end
  end

  // Shifting a 64-bit window yields both halves of a split access at once:
  // low half belongs to word A, high half to word B.
  always_comb begin
    off    = addr[1:0];
    sh     = {off, 3'b000};
    bad    = (funct3 == 3'b011) | (funct3[2] & funct3[1]) | (is_store & funct3[2]);
    mis    = ((funct3[1:0] == 2'b01) & (off == 2'd3)) |
             ((funct3[1:0] == 2'b10) & (off != 2'd0));
    case (funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    mask8  = {4'b0000, base_mask} << off;
    wshift = {32'd0, wdata} << sh;
    lshift = {mem_rdata, lo_buf} >> sh;

    state_nx  = IDLE;
    mem_addr  = {addr[31:2], 2'b00};
    mem_wdata = wshift[31:0];
    mem_wmask = 4'b0000;
    stall     = 1'b0;
    misalign  = 1'b0;
    bad_op    = 1'b0;
    ld_en     = 1'b0;
    raw       = '0;

    if (rst) begin
      state_nx = IDLE;
    end else if (state == SECOND) begin
      // A dropped request in SECOND aborts without touching memory.
      if (req_valid) begin
        mem_addr  = {addr[31:2], 2'b00} + 32'd4;
        mem_wdata = wshift[63:32];
        if (is_store) mem_wmask = mask8[7:4];
        raw   = lshift[31:0];
        ld_en = 1'b1;
      end
    end else if (req_valid) begin
      if (bad) begin
        bad_op = 1'b1;
      end else if (mis && !MISALIGN_EN) begin
        misalign = 1'b1;
      end else begin
        if (is_store) mem_wmask = mask8[3:0];
        if (mis) begin
          stall    = 1'b1;
          state_nx = SECOND;
        end else begin
          raw   = mem_rdata >> sh;
          ld_en = 1'b1;
        end
      end
    end

    load_data = '0;
    if (ld_en && !is_store) begin
      case (funct3)
        3'b000:  load_data = {{24{raw[7]}}, raw[7:0]};
        3'b001:  load_data = {{16{raw[15]}}, raw[15:0]};
        3'b100:  load_data = {24'd0, raw[7:0]};
        3'b101:  load_data = {16'd0, raw[15:0]};
        default: load_data = raw;
      endcase
    end

    mem_we = req_valid & is_store & (mem_wmask != 4'b0000) & ~rst;
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// tb/tb_lsu_align_unit.sv - self-checking bench for lsu_align_unit
// Checks against a byte-addressed memory model with randomized accesses.
module tb_lsu_align_unit;

  logic        clk, rst, req_valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] mem_addr_a, mem_wdata_a, load_data_a;
  logic [3:0]  mem_wmask_a;
  logic        mem_we_a, stall_a, misalign_a, bad_op_a;
  logic [31:0] mem_addr_b, mem_wdata_b, load_data_b;
  logic [3:0]  mem_wmask_b;
  logic        mem_we_b, stall_b, misalign_b, bad_op_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] memw   [logic [31:0]];
  logic [7:0]  wr_mem [logic [31:0]];

  int          ncyc;
  logic [31:0] c_addr [4];
  logic [31:0] c_wdata[4];
  logic [3:0]  c_mask [4];
  logic        c_stall[4];
  logic        c_we   [4];
  logic        c_mis_b[4];
  logic        c_we_b [4];
  logic        c_bad;
  logic [31:0] c_ld, c_ld_b;

  lsu_align_unit #(.MISALIGN_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wmask(mem_wmask_a),
    .mem_we(mem_we_a), .load_data(load_data_a), .stall(stall_a),
    .misalign(misalign_a), .bad_op(bad_op_a)
  );

  lsu_align_unit #(.MISALIGN_EN(1'b0)) u_dut_nm (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wmask(mem_wmask_b),
    .mem_we(mem_we_b), .load_data(load_data_b), .stall(stall_b),
    .misalign(misalign_b), .bad_op(bad_op_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (memw.exists(a)) return memw[a];
    return (a * 32'h9E3779B1) ^ 32'h5A3C96E1;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = memword({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = nbytes(f3);
    v = '0;
    for (int i = 0; i < n; i++) v = v + (32'(mem_byte(a + 32'(i))) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic sample_writes();
    if (mem_we_a)
      for (int l = 0; l < 4; l++)
        if (mem_wmask_a[l]) wr_mem[mem_addr_a + 32'(l)] = mem_wdata_a[8*l +: 8];
  endtask

  // Entered just after a rising edge; leaves just after the final edge.
  task automatic access(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    bit done;
    wr_mem.delete();
    is_store = st; funct3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
    ncyc = 0; done = 0;
    while (!done && ncyc < 4) begin
      #1 mem_rdata = memword(mem_addr_a);
      @(negedge clk);
      c_addr[ncyc]  = mem_addr_a;  c_wdata[ncyc] = mem_wdata_a;
      c_mask[ncyc]  = mem_wmask_a; c_stall[ncyc] = stall_a;
      c_we[ncyc]    = mem_we_a;    c_mis_b[ncyc] = misalign_b;
      c_we_b[ncyc]  = mem_we_b;
      if (ncyc == 0) begin c_bad = bad_op_a; c_ld_b = load_data_b; end
      c_ld = load_data_a;
      sample_writes();
      ncyc++;
      if (!stall_a) done = 1;
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010;
    addr = 32'h0000_0103; wdata = 32'hCAFEF00D; mem_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall_a); end
    n_cmp++; if (mem_we_a !== 1'b0 || mem_we_b !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b/%b want 0/0", mem_we_a, mem_we_b); end
    n_cmp++; if (mem_wmask_a !== 4'b0) begin n_bad++; $display("FAIL reset_mask got %b want 0000", mem_wmask_a); end
    n_cmp++; if (mem_addr_a !== 32'h100) begin n_bad++; $display("FAIL reset_addr got %h want 00000100", mem_addr_a); end
    n_cmp++; if (misalign_b !== 1'b0 || bad_op_a !== 1'b0 || load_data_a !== 32'd0) begin
      n_bad++; $display("FAIL reset_flags got mis=%b bad=%b ld=%h want 0/0/0", misalign_b, bad_op_a, load_data_a); end
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall_a !== 1'b0 || mem_wmask_a !== 4'b0 || load_data_a !== 32'd0) begin
      n_bad++; $display("FAIL idle_outputs got st=%b mask=%b ld=%h want 0", stall_a, mem_wmask_a, load_data_a); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_aligned();
    memw[32'h100] = 32'hDEADBEEF;
    access(1'b0, 3'b010, 32'h100, 32'd0);
    n_cmp++; if (ncyc != 1 || c_stall[0] !== 1'b0) begin n_bad++; $display("FAIL lw_cycles got %0d want 1", ncyc); end
    n_cmp++; if (c_addr[0] !== 32'h100) begin n_bad++; $display("FAIL lw_addr got %h want 00000100", c_addr[0]); end
    n_cmp++; if (c_ld !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data got %h want deadbeef", c_ld); end
    memw[32'h100] = 32'h80123456;
    access(1'b0, 3'b000, 32'h103, 32'd0);
    n_cmp++; if (c_ld !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_data got %h want ffffff80", c_ld); end
    access(1'b0, 3'b100, 32'h103, 32'd0);
    n_cmp++; if (c_ld !== 32'h00000080) begin n_bad++; $display("FAIL lbu_data got %h want 00000080", c_ld); end
    access(1'b1, 3'b000, 32'h102, 32'h0000_00AB);
    n_cmp++; if (c_mask[0] !== 4'b0100 || c_wdata[0] !== 32'h00AB0000 || c_we[0] !== 1'b1) begin
      n_bad++; $display("FAIL sb_lane got mask=%b data=%h we=%b want 0100/00ab0000/1", c_mask[0], c_wdata[0], c_we[0]); end
  endtask

  task automatic test_misaligned();
    memw[32'h100] = 32'h44332211;
    memw[32'h104] = 32'h88776655;
    access(1'b0, 3'b010, 32'h101, 32'd0);
    n_cmp++; if (ncyc != 2 || c_stall[0] !== 1'b1 || c_stall[1] !== 1'b0) begin
      n_bad++; $display("FAIL mlw_stall got cycles=%0d want 2 with stall 1,0", ncyc); end
    n_cmp++; if (c_addr[0] !== 32'h100 || c_addr[1] !== 32'h104) begin
      n_bad++; $display("FAIL mlw_addr got %h,%h want 00000100,00000104", c_addr[0], c_addr[1]); end
    n_cmp++; if (c_ld !== 32'h55443322) begin n_bad++; $display("FAIL mlw_data got %h want 55443322", c_ld); end
    access(1'b1, 3'b001, 32'h203, 32'h0000_BEEF);
    n_cmp++; if (c_mask[0] !== 4'b1000 || c_wdata[0] !== 32'hEF000000 || c_addr[0] !== 32'h200) begin
      n_bad++; $display("FAIL msh_a got mask=%b data=%h addr=%h want 1000/ef000000/00000200", c_mask[0], c_wdata[0], c_addr[0]); end
    n_cmp++; if (c_mask[1] !== 4'b0001 || c_wdata[1] !== 32'h000000BE || c_addr[1] !== 32'h204) begin
      n_bad++; $display("FAIL msh_b got mask=%b data=%h addr=%h want 0001/000000be/00000204", c_mask[1], c_wdata[1], c_addr[1]); end
  endtask

  task automatic test_wrap_and_bad_op();
    access(1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0);
    n_cmp++; if (ncyc != 2 || c_addr[1] !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got %h want 00000000", c_addr[1]); end
    n_cmp++; if (c_ld !== ref_load(3'b010, 32'hFFFF_FFFE)) begin
      n_bad++; $display("FAIL wrap_data got %h want %h", c_ld, ref_load(3'b010, 32'hFFFF_FFFE)); end
    access(1'b0, 3'b011, 32'h100, 32'd0);
    n_cmp++; if (c_bad !== 1'b1 || c_ld !== 32'd0 || ncyc != 1) begin
      n_bad++; $display("FAIL bad_load got bad=%b ld=%h cycles=%0d want 1/0/1", c_bad, c_ld, ncyc); end
    access(1'b1, 3'b100, 32'h101, 32'hFFFF_FFFF);
    n_cmp++; if (c_bad !== 1'b1 || c_we[0] !== 1'b0 || wr_mem.num() != 0) begin
      n_bad++; $display("FAIL bad_store got bad=%b we=%b writes=%0d want 1/0/0", c_bad, c_we[0], wr_mem.num()); end
  endtask

  task automatic test_reset_second();
    wr_mem.delete();
    is_store = 1'b1; funct3 = 3'b010; addr = 32'h2; wdata = 32'h11223344; req_valid = 1'b1;
    #1 mem_rdata = memword(mem_addr_a);
    @(negedge clk);
    n_cmp++; if (stall_a !== 1'b1) begin n_bad++; $display("FAIL rs_stall1 got %b want 1", stall_a); end
    n_cmp++; if (misalign_b !== 1'b1 || mem_we_b !== 1'b0 || stall_b !== 1'b0) begin
      n_bad++; $display("FAIL nm_flag got mis=%b we=%b stall=%b want 1/0/0", misalign_b, mem_we_b, stall_b); end
    sample_writes();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_we_a !== 1'b0 || stall_a !== 1'b0) begin
      n_bad++; $display("FAIL rs_second got we=%b stall=%b want 0/0", mem_we_a, stall_a); end
    sample_writes();
    @(posedge clk);
    #1 rst = 1'b0; is_store = 1'b0; addr = 32'h100;
    @(negedge clk);
    n_cmp++; if (stall_a !== 1'b0 || mem_addr_a !== 32'h100) begin
      n_bad++; $display("FAIL rs_after got stall=%b addr=%h want 0/00000100", stall_a, mem_addr_a); end
    n_cmp++; if (wr_mem.num() != 2 || !wr_mem.exists(32'h2) || wr_mem[32'h2] !== 8'h44 || wr_mem.exists(32'h4)) begin
      n_bad++; $display("FAIL rs_writes got %0d bytes want only 0x2,0x3", wr_mem.num()); end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_abort();
    is_store = 1'b1; funct3 = 3'b001; addr = 32'h3; wdata = 32'h5555; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall_a !== 1'b0 || mem_wmask_a !== 4'b0 || mem_we_a !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle got stall=%b mask=%b we=%b want 0", stall_a, mem_wmask_a, mem_we_a); end
    @(posedge clk);
    #1;
    access(1'b1, 3'b010, 32'h10, 32'h0BADF00D);
    n_cmp++; if (ncyc != 1 || c_addr[0] !== 32'h10 || c_mask[0] !== 4'b1111) begin
      n_bad++; $display("FAIL abort_next got cycles=%0d addr=%h mask=%b want 1/00000010/1111", ncyc, c_addr[0], c_mask[0]); end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, wd, bad_byte_addr;
    logic        st, mis;
    bit          ok;
    int          n;
    logic [2:0]  ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int t = 0; t < 300; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
      a  = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      wd = $urandom();
      n  = nbytes(f3);
      mis = (32'(a[1:0]) + 32'(n)) > 32'd4;
      access(st, f3, a, wd);
      n_cmp++; if (ncyc != (mis ? 2 : 1)) begin
        n_bad++; $display("FAIL rnd_cycles t=%0d got %0d want %0d", t, ncyc, mis ? 2 : 1); end
      n_cmp++; if (c_addr[0] !== (a & ~32'd3) || (mis && c_addr[1] !== (a & ~32'd3) + 32'd4)) begin
        n_bad++; $display("FAIL rnd_addr t=%0d a=%h got %h,%h", t, a, c_addr[0], c_addr[1]); end
      n_cmp++; if (c_mis_b[0] !== mis || (mis && c_we_b[0] !== 1'b0) || (mis && c_ld_b !== 32'd0)) begin
        n_bad++; $display("FAIL rnd_nomis t=%0d got mis=%b we=%b ld=%h want mis=%b", t, c_mis_b[0], c_we_b[0], c_ld_b, mis); end
      if (st) begin
        ok = (wr_mem.num() == n);
        bad_byte_addr = '0;
        for (int i = 0; i < n; i++)
          if (!wr_mem.exists(a + 32'(i)) || wr_mem[a + 32'(i)] !== wd[8*i +: 8]) begin
            ok = 0; bad_byte_addr = a + 32'(i);
          end
        n_cmp++; if (!ok) begin
          n_bad++; $display("FAIL rnd_store t=%0d f3=%0d a=%h got %0d bytes (bad at %h) want %0d", t, f3, a, wr_mem.num(), bad_byte_addr, n); end
      end else begin
        n_cmp++; if (c_ld !== ref_load(f3, a) || wr_mem.num() != 0) begin
          n_bad++; $display("FAIL rnd_load t=%0d f3=%0d a=%h got %h want %h", t, f3, a, c_ld, ref_load(f3, a)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; mem_rdata = '0;
    test_reset();
    test_aligned();
    test_misaligned();
    test_wrap_and_bad_op();
    test_reset_second();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_align_unit.md
# lsu_align_unit

Load/store alignment unit between the RV32I core's memory stage and the data memory path. It turns byte/half/word load and store requests into word-aligned memory accesses with per-byte write masks. It splits misaligned halfword and word accesses into two consecutive word accesses, stalling the core for one cycle. It also extracts, recombines and sign/zero-extends load data from the word returned by the memory output mux.

## Interface
- MISALIGN_EN, default 1: 1 = split misaligned accesses in hardware; 0 = flag them on `misalign` and perform no access.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core issues a load or store this cycle; held stable while `stall`=1.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- mem_rdata  in  32  word read from the memory output mux, combinational in the same cycle as `mem_addr`.
- mem_addr  out  32  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  32  lane-positioned store data.
- mem_wmask  out  4  byte-lane write enables.
- mem_we  out  1  write strobe, sampled by memory on clk edge.
- load_data  out  32  extended load result, valid when `req_valid & ~stall & ~is_store`.
- stall  out  1  hold core PC/pipeline this cycle.
- misalign  out  1  misaligned request with MISALIGN_EN=0.
- bad_op  out  1  illegal funct3 (011, 110, 111; 100/101 with is_store).

## Operation
- State: IDLE, SECOND. Latch `lo_buf` (32 b) holds word-A read data.
- Let o = addr[1:0], n = 1/2/4 bytes. Misaligned when o+n > 4, i.e. H with o=3, W with o≠0.
- Aligned, IDLE: mem_addr = {addr[31:2],2'b00}; store mask = n lanes starting at lane o; mem_wdata = wdata << 8·o (truncated to 32 b); load takes lanes o..o+n-1 of mem_rdata. stall=0. State stays IDLE.
- Misaligned, MISALIGN_EN=1, IDLE: word A at addr&~3. Store mask = lanes o..3, mem_wdata = wdata << 8·o. Loads capture mem_rdata into lo_buf. stall=1. Next state SECOND.
- SECOND: word B at (addr&~3)+4, wrapping modulo 2^32. Store mask = lanes 0..(o+n-5), mem_wdata = wdata >> 8·(4-o). Load result byte i comes from lo_buf lane o+i for i < 4-o, else from mem_rdata lane i-(4-o). stall=0. Next state IDLE.
- Misaligned, MISALIGN_EN=0: misalign=1, mem_we=0, mem_wmask=0, load_data=0, stall=0.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- bad_op: mem_we=0, load_data=0, stall=0, no state change.
- mem_we = req_valid & is_store & (mem_wmask≠0) & ~rst.
- req_valid=0 in SECOND: abort to IDLE; no access is performed.
- Idle outputs (req_valid=0): mem_addr={addr[31:2],00}, mem_wmask=0, mem_we=0, load_data=0, stall=0, misalign=0, bad_op=0.

## Timing
- Reset: state=IDLE, lo_buf=0. While rst=1, all outputs are forced to their idle values (mem_we=0, stall=0).
- Reset asserted in SECOND: the second write is suppressed. The next cycle is IDLE.
- Aligned access: 0 added cycles. Load data is combinational from mem_rdata in the same cycle. The store commits at the end-of-cycle edge.
- Misaligned access: exactly 2 cycles with stall pattern 1,0. Word A is written at edge 1 and word B at edge 2.
- Only state and lo_buf are registered. All other outputs are combinational from inputs and state.

## Test plan
- Aligned LW addr 0x100, mem_rdata 0xDEADBEEF -> load_data 0xDEADBEEF, stall 0, mem_addr 0x100.
- LB addr 0x103 with mem_rdata 0x80123456 -> 0xFFFFFF80; LBU same -> 0x00000080; SB wdata 0xAB at 0x102 -> mask 0100, mem_wdata 0x00AB0000.
- Misaligned LW addr 0x101, word A 0x44332211, word B 0x88776655 -> cycle 1 stall 1, mem_addr 0x100; cycle 2 stall 0, mem_addr 0x104, load_data 0x55443322.
- Misaligned SH wdata 0xBEEF at 0x203 -> cycle 1 mask 1000, mem_wdata 0xEF000000 at 0x200; cycle 2 mask 0001, mem_wdata 0x000000BE at 0x204.
- rst pulsed during SECOND of SW at 0x2 -> no write in the reset cycle; state IDLE and stall 0 afterwards. Repeat with MISALIGN_EN=0 -> misalign 1, mem_we 0.
- LW at 0xFFFFFFFE -> word B address wraps to 0x00000000. funct3=011 -> bad_op 1, mem_we 0.
